// File: rtl/stitch_pipeline_out_buffer_if.sv
// -----------------------------------------------------------------------------
// stitch_pipeline_out_buffer_if
//
// Bundles the upstream admission handshake, the pipeline result bus and the
// downstream valid/ready result channel of stitch_pipeline_out_buffer.
//
// Signals:
//   s_valid   upstream presents a transaction to the pipeline inputs
//   s_ready   admission grant (transfer on s_valid && s_ready)
//   pipe_out  registered output of the stitched pipeline
//   m_valid   result available
//   m_ready   downstream accepts the result
//   m_data    result data
//
// Modports:
//   slave   the output buffer itself
//   master  the surrounding environment (upstream source, pipeline, sink)
// -----------------------------------------------------------------------------
interface stitch_pipeline_out_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] pipe_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid,
    input  pipe_out,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data
  );

  modport master (
    output s_valid,
    output pipe_out,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/stitch_pipeline_out_buffer.sv
// -----------------------------------------------------------------------------
// stitch_pipeline_out_buffer
//
// Elastic output stage for a stall-free, fixed-latency stitched pipeline.
// Accepted transactions are tracked through the pipeline with a valid shift
// register; each arriving result is captured in a small FIFO and presented on
// a valid/ready channel. Admission is throttled on (FIFO count + in-flight) so
// an arriving result can never find the FIFO full.
//
// Ports:
//   clk    sole clock, posedge
//   rst_n  synchronous active-low reset
//   bus    stitch_pipeline_out_buffer_if.slave
//          (s_valid/s_ready, pipe_out, m_valid/m_ready/m_data)
//
// Parameters:
//   DATA_WIDTH  result width
//   LATENCY     accept-to-pipe_out latency in cycles (>= 1)
//   DEPTH       FIFO entries (>= 1, any value)
//
// Build option:
//   STITCH_OUT_BUF_BYPASS_EN  when defined, a result arriving at an empty FIFO
//                             is presented combinationally from pipe_out in its
//                             arrival cycle and only pushed if not taken.
// -----------------------------------------------------------------------------
module stitch_pipeline_out_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH      = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  stitch_pipeline_out_buffer_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned InfW = $clog2(LATENCY + 1);
  localparam int unsigned OccW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [InfW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            accept, arrive, push, pop, empty, full;
  logic [OccW-1:0] occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Registered state only: no m_ready -> s_ready combinational path.
  assign occupancy   = OccW'(count_q) + OccW'(inflight_q);
  assign bus.s_ready = occupancy < OccW'(DEPTH);

  assign accept = bus.s_valid && bus.s_ready;
  assign arrive = vld_q[LATENCY-1];
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));
  assign pop    = bus.m_ready && !empty;

`ifdef STITCH_OUT_BUF_BYPASS_EN
  logic bypass;
  assign bypass      = arrive && empty;
  assign bus.m_valid = !empty || bypass;
  assign bus.m_data  = bypass ? bus.pipe_out : mem_q[rd_ptr_q];
  // A bypassed result taken in its arrival cycle never enters the FIFO.
  assign push        = arrive && !(bypass && bus.m_ready);
`else
  assign bus.m_valid = !empty;
  assign bus.m_data  = mem_q[rd_ptr_q];
  assign push        = arrive;
`endif

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    inflight_d = inflight_q;
    if (accept && !arrive) begin
      inflight_d = inflight_q + InfW'(1);
    end else if (!accept && arrive) begin
      inflight_d = inflight_q - InfW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.pipe_out;
      end
    end
  end

`ifndef SYNTHESIS
  // Admission control makes this unreachable; firing means a credit bug.
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop && full) begin
      $error("stitch_pipeline_out_buffer: push into full FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_stitch_pipeline_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_stitch_pipeline_out_buffer
//
// Directed bench for stitch_pipeline_out_buffer with LATENCY=2, DEPTH=4.
// A two-stage register chain stands in for the external pipeline, so the
// value driven on in_data during an accept cycle reaches pipe_out two cycles
// later. Inputs change and outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_stitch_pipeline_out_buffer;

  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  logic [DW-1:0] in_data;
  logic [DW-1:0] p0, p1;

  int n_cmp = 0;
  int n_bad = 0;

  stitch_pipeline_out_buffer_if #(.DATA_WIDTH(DW)) ifc ();

  stitch_pipeline_out_buffer #(
    .DATA_WIDTH(DW),
    .LATENCY   (2),
    .DEPTH     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stall-free pipeline model: two register stages.
  always @(posedge clk) begin
    p0 <= in_data;
    p1 <= p0;
  end
  assign ifc.pipe_out = p1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.m_ready = 1'b0;
    in_data     = 32'h55;

    // Reset held 3 cycles with s_valid high.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_s_ready_%0d", i), 32'(ifc.s_ready), 32'd1);
      check($sformatf("rst_m_valid_%0d", i), 32'(ifc.m_valid), 32'd0);
      check($sformatf("rst_m_data_%0d", i), ifc.m_data, 32'd0);
    end

    // Release with s_valid low: nothing may emerge from the reset cycles.
    rst_n       = 1'b1;
    ifc.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_m_valid_%0d", i), 32'(ifc.m_valid), 32'd0);
      step();
    end

    // Single transaction, data 7.
    ifc.s_valid = 1'b1;
    ifc.m_ready = 1'b1;
    in_data     = 32'h7;
    check("single_s_ready", 32'(ifc.s_ready), 32'd1);
    step();
    ifc.s_valid = 1'b0;
    in_data     = 32'hDEAD_BEEF;
    check("single_t1_m_valid", 32'(ifc.m_valid), 32'd0);
    step();
`ifdef STITCH_OUT_BUF_BYPASS_EN
    check("single_t2_m_valid", 32'(ifc.m_valid), 32'd1);
    check("single_t2_m_data", ifc.m_data, 32'h7);
    step();
    check("single_t3_m_valid", 32'(ifc.m_valid), 32'd0);
`else
    check("single_t2_m_valid", 32'(ifc.m_valid), 32'd0);
    step();
    check("single_t3_m_valid", 32'(ifc.m_valid), 32'd1);
    check("single_t3_m_data", ifc.m_data, 32'h7);
`endif
    step();
    check("single_t4_m_valid", 32'(ifc.m_valid), 32'd0);

    // Streaming: 100 accepts, results 0..99 one per cycle from cycle 3.
    ifc.m_ready = 1'b1;
    for (int k = 0; k < 104; k++) begin
      logic exp_v;
      ifc.s_valid = (k < 100);
      in_data     = 32'(k);
      exp_v       = (k >= 3) && (k < 103);
      check($sformatf("stream_s_ready_%0d", k), 32'(ifc.s_ready), 32'd1);
      check($sformatf("stream_m_valid_%0d", k), 32'(ifc.m_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("stream_m_data_%0d", k), ifc.m_data, 32'(k - 3));
      end
      step();
    end

    // Backpressure: exactly 4 accepts (100..103), head held at 100.
    ifc.s_valid = 1'b1;
    ifc.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'(100 + k);
      check($sformatf("bp_s_ready_%0d", k), 32'(ifc.s_ready), 32'(k < 4));
      check($sformatf("bp_m_valid_%0d", k), 32'(ifc.m_valid), 32'(k >= 3));
      if (k >= 3) begin
        check($sformatf("bp_m_data_%0d", k), ifc.m_data, 32'd100);
      end
      step();
    end
    check("bp_count_full", 32'(dut.count_q), 32'd4);
    check("bp_full_s_ready", 32'(ifc.s_ready), 32'd0);
    check("bp_full_m_data", ifc.m_data, 32'd100);
    ifc.m_ready = 1'b1;  // single-cycle pop of 100
    step();
    ifc.m_ready = 1'b0;
    in_data     = 32'd104;
    check("bp_after_pop_s_ready", 32'(ifc.s_ready), 32'd1);
    check("bp_after_pop_m_data", ifc.m_data, 32'd101);
    step();                // 104 accepted above
    ifc.s_valid = 1'b0;
    check("bp_refill_s_ready", 32'(ifc.s_ready), 32'd0);
    check("bp_refill_m_data", ifc.m_data, 32'd101);
    step();

    // Arrival of 104 coincides with a pop: count must stay, order preserved.
    ifc.m_ready = 1'b1;
    check("pp_count_before", 32'(dut.count_q), 32'd3);
    check("pp_m_data_101", ifc.m_data, 32'd101);
    check("pp_s_ready_before", 32'(ifc.s_ready), 32'd0);
    step();
    check("pp_count_after", 32'(dut.count_q), 32'd3);
    check("pp_m_data_102", ifc.m_data, 32'd102);
    check("pp_s_ready_after", 32'(ifc.s_ready), 32'd1);
    step();
    check("pp_m_data_103", ifc.m_data, 32'd103);
    step();
    check("pp_m_data_104", ifc.m_data, 32'd104);
    check("pp_m_valid_104", 32'(ifc.m_valid), 32'd1);
    step();
    check("pp_drained", 32'(ifc.m_valid), 32'd0);
    ifc.m_ready = 1'b0;

    // Reset mid-flight: two accepts discarded, stale pipe_out never shown.
    ifc.s_valid = 1'b1;
    in_data     = 32'd200;
    step();
    in_data = 32'd201;
    step();
    ifc.s_valid = 1'b0;
    in_data     = 32'd0;
    rst_n       = 1'b0;
    check("mid_rst_m_valid", 32'(ifc.m_valid), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mid_rst_after_m_valid_%0d", i), 32'(ifc.m_valid), 32'd0);
      check($sformatf("mid_rst_after_m_data_%0d", i), ifc.m_data, 32'd0);
      check($sformatf("mid_rst_after_s_ready_%0d", i), 32'(ifc.s_ready), 32'd1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
